// File: rtl/paralelo_serial_tx.sv
// Transmit serializer: 9-bit {valid, byte} words out as 2-bit pairs, MSB pair first.
// A COM preamble of SYNC_COUNT symbols follows every reset so the receiver can align.
module paralelo_serial_tx #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter logic [7:0]  IDLE       = 8'h7C,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_16,
  input  logic       reset,
  input  logic [8:0] in_paralelo,
  output logic [1:0] serial,
  output logic       load,
  output logic       active
);

  localparam int unsigned SYM_W   = 8;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned CNT_W   = 4;

  localparam logic [CNT_W-1:0]   SYNC_LAST  = CNT_W'(SYNC_COUNT - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = '1;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [SYM_W-1:0]   shift;
  logic [CNT_W-1:0]   sync_cnt;

  logic               sym_end;
  logic               sync_done;
  logic [SYM_W-1:0]   next_sym;

  // Symbol boundary decode and the word picked up at that boundary
  assign sym_end   = (phase == PHASE_LAST);
  assign sync_done = (sync_cnt == SYNC_LAST);
  assign next_sym  = in_paralelo[8] ? in_paralelo[SYM_W-1:0] : IDLE;

  assign load   = sym_end && ((state == ST_ACTIVE) || ((state == ST_SYNC) && sync_done));
  assign serial = shift[SYM_W-1 -: 2];

  // Preamble / data state machine; unknown encodings restart like RESET
  always_ff @(posedge clk_16 or posedge reset) begin
    if (reset) begin
      state    <= ST_RESET;
      phase    <= '0;
      shift    <= '0;
      sync_cnt <= '0;
      active   <= 1'b0;
    end else begin
      case (state)
        ST_SYNC: begin
          if (sym_end) begin
            phase <= '0;
            if (sync_done) begin
              state    <= ST_ACTIVE;
              active   <= 1'b1;
              sync_cnt <= '0;
              shift    <= next_sym;
            end else begin
              sync_cnt <= sync_cnt + CNT_W'(1);
              shift    <= COM;
            end
          end else begin
            phase <= phase + PHASE_W'(1);
            shift <= {shift[SYM_W-3:0], 2'b00};
          end
        end
        ST_ACTIVE: begin
          if (sym_end) begin
            phase <= '0;
            shift <= next_sym;
          end else begin
            phase <= phase + PHASE_W'(1);
            shift <= {shift[SYM_W-3:0], 2'b00};
          end
        end
        default: begin
          state    <= ST_SYNC;
          phase    <= '0;
          shift    <= COM;
          sync_cnt <= '0;
          active   <= 1'b0;
        end
      endcase
    end
  end

endmodule
